// File: rtl/multi_circle_renderer_if.sv
// Pixel, keypad and status bundle between the renderer and its surroundings.
// The renderer takes the slave side; the driving environment takes the master side.
interface multi_circle_renderer_if #(
   parameter int N_CIRCLES = 4
);
   logic [4:0]              key_code;
   logic                    key_ready;
   logic                    frame_start;
   logic [9:0]              col_addr;
   logic [8:0]              row_addr;
   logic [12*N_CIRCLES-1:0] color_in;
   logic [11:0]             bg_color;
   logic [11:0]             vga_data;
   logic [N_CIRCLES-1:0]    hit;
   logic [1:0]              sel_idx;
   logic [9:0]              sel_x;
   logic [8:0]              sel_y;
   logic [9:0]              sel_r;

   modport master (
      output key_code, key_ready, frame_start, col_addr, row_addr, color_in, bg_color,
      input  vga_data, hit, sel_idx, sel_x, sel_y, sel_r
   );

   modport slave (
      input  key_code, key_ready, frame_start, col_addr, row_addr, color_in, bg_color,
      output vga_data, hit, sel_idx, sel_x, sel_y, sel_r
   );
endinterface

// File: rtl/multi_circle_renderer.sv
// Multi-circle VGA overlay: keypad edits a double-buffered circle set, two-stage pixel pipeline.
// Define CIRCLE_OUTLINE_EN to draw OUTLINE_W-thick rings instead of filled discs.
module multi_circle_renderer #(
   parameter int N_CIRCLES = 4,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int STEP_XY   = 20,
   parameter int STEP_R    = 5,
   parameter int R_MIN     = 5,
   parameter int R_MAX     = 200,
   parameter int R_INIT    = 15,
   parameter int OUTLINE_W = 3
) (
   input logic                   clk,
   input logic                   rstn,
   multi_circle_renderer_if.slave bus
);
   localparam logic signed [10:0] X_MAX    = 11'(H_RES - 1);
   localparam logic signed [10:0] Y_MAX    = 11'(V_RES - 1);
   localparam logic signed [10:0] ZERO     = 11'sd0;
   localparam logic signed [10:0] STEP_P   = 11'(STEP_XY);
   localparam logic signed [10:0] RSTEP_P  = 11'(STEP_R);
   localparam logic signed [10:0] RLO      = 11'(R_MIN);
   localparam logic signed [10:0] RHI      = 11'(R_MAX);
   localparam logic [4:0]         NUM_CODE = 5'(N_CIRCLES);

   function automatic logic [9:0] resetX(input int i);
      return 10'((2 * i + 1) * H_RES / (2 * N_CIRCLES));
   endfunction

   // Saturating signed step; the 11-bit sum can never wrap for any legal coordinate.
   function automatic logic [9:0] clampStep(input logic [9:0] v, input logic signed [10:0] delta,
                                            input logic signed [10:0] lo, input logic signed [10:0] hi);
      logic signed [10:0] s;
      s = $signed({1'b0, v}) + delta;
      if (s < lo)      s = lo;
      else if (s > hi) s = hi;
      return s[9:0];
   endfunction

   logic                 wasReady_q;
   logic [1:0]           selIdx_q, selIdx_d;
   logic [9:0]           editX_q [N_CIRCLES];
   logic [9:0]           editY_q [N_CIRCLES];
   logic [9:0]           editR_q [N_CIRCLES];
   logic [9:0]           editX_d [N_CIRCLES];
   logic [9:0]           editY_d [N_CIRCLES];
   logic [9:0]           editR_d [N_CIRCLES];
   logic [9:0]           dispX_q [N_CIRCLES];
   logic [9:0]           dispY_q [N_CIRCLES];
   logic [9:0]           dispR_q [N_CIRCLES];
   logic [20:0]          d2_q    [N_CIRCLES];
   logic [20:0]          d2_d    [N_CIRCLES];
   logic [19:0]          r2_q    [N_CIRCLES];
   logic [19:0]          r2_d    [N_CIRCLES];
   logic [11:0]          bg_q;
   logic [11:0]          vga_q, vga_d;
   logic [N_CIRCLES-1:0] hit_q, hit_d;
   logic                 keyEvent;
   logic signed [10:0]   dx, dy;

`ifdef CIRCLE_OUTLINE_EN
   logic [19:0]          rIn2_q  [N_CIRCLES];
   logic [19:0]          rIn2_d  [N_CIRCLES];
   logic [9:0]           rIn;
`else
   logic                 unusedOutline;
   assign unusedOutline = ^10'(OUTLINE_W);
`endif

   assign keyEvent = bus.key_ready && !wasReady_q;

   always_comb begin
      selIdx_d = selIdx_q;
      editX_d  = editX_q;
      editY_d  = editY_q;
      editR_d  = editR_q;
      if (keyEvent) begin
         case (bus.key_code)
            5'h00, 5'h01, 5'h02, 5'h03:
               if (bus.key_code < NUM_CODE) selIdx_d = bus.key_code[1:0];
            5'h0c: editX_d[selIdx_q] = clampStep(editX_q[selIdx_q], -STEP_P, ZERO, X_MAX);
            5'h0e: editX_d[selIdx_q] = clampStep(editX_q[selIdx_q], STEP_P, ZERO, X_MAX);
            5'h09: editY_d[selIdx_q] = clampStep(editY_q[selIdx_q], -STEP_P, ZERO, Y_MAX);
            5'h11: editY_d[selIdx_q] = clampStep(editY_q[selIdx_q], STEP_P, ZERO, Y_MAX);
            5'h10: editR_d[selIdx_q] = clampStep(editR_q[selIdx_q], -RSTEP_P, RLO, RHI);
            5'h12: editR_d[selIdx_q] = clampStep(editR_q[selIdx_q], RSTEP_P, RLO, RHI);
            default: ;
         endcase
      end
   end

   // Stage 1: squared distance of the pixel to each displayed centre, plus squared radii.
   always_comb begin
      dx = '0;
      dy = '0;
`ifdef CIRCLE_OUTLINE_EN
      rIn = '0;
`endif
      for (int i = 0; i < N_CIRCLES; i++) begin
         dx      = $signed({1'b0, bus.col_addr}) - $signed({1'b0, dispX_q[i]});
         dy      = $signed({2'b0, bus.row_addr}) - $signed({1'b0, dispY_q[i]});
         d2_d[i] = {{10{dx[10]}}, dx} * {{10{dx[10]}}, dx} + {{10{dy[10]}}, dy} * {{10{dy[10]}}, dy};
         r2_d[i] = {10'b0, dispR_q[i]} * {10'b0, dispR_q[i]};
`ifdef CIRCLE_OUTLINE_EN
         rIn       = (dispR_q[i] > 10'(OUTLINE_W)) ? dispR_q[i] - 10'(OUTLINE_W) : 10'd0;
         rIn2_d[i] = {10'b0, rIn} * {10'b0, rIn};
`endif
      end
   end

   // Stage 2: coverage test and lowest-index-wins colour priority.
   always_comb begin
      hit_d = '0;
      vga_d = bg_q;
      for (int i = 0; i < N_CIRCLES; i++) begin
`ifdef CIRCLE_OUTLINE_EN
         hit_d[i] = (d2_q[i] < {1'b0, r2_q[i]}) && (d2_q[i] >= {1'b0, rIn2_q[i]});
`else
         hit_d[i] = (d2_q[i] < {1'b0, r2_q[i]});
`endif
      end
      for (int i = N_CIRCLES - 1; i >= 0; i--) begin
         if (hit_d[i]) vga_d = bus.color_in[12*i +: 12];
      end
   end

   // Display copies sample the pre-edit state, so a same-cycle edit waits for the next frame.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wasReady_q <= 1'b0;
         selIdx_q   <= '0;
         bg_q       <= '0;
         vga_q      <= '0;
         hit_q      <= '0;
         for (int i = 0; i < N_CIRCLES; i++) begin
            editX_q[i] <= resetX(i);
            editY_q[i] <= 10'(V_RES / 2);
            editR_q[i] <= 10'(R_INIT);
            dispX_q[i] <= resetX(i);
            dispY_q[i] <= 10'(V_RES / 2);
            dispR_q[i] <= 10'(R_INIT);
            d2_q[i]    <= '0;
            r2_q[i]    <= '0;
`ifdef CIRCLE_OUTLINE_EN
            rIn2_q[i]  <= '0;
`endif
         end
      end else begin
         wasReady_q <= bus.key_ready;
         selIdx_q   <= selIdx_d;
         editX_q    <= editX_d;
         editY_q    <= editY_d;
         editR_q    <= editR_d;
         if (bus.frame_start) begin
            dispX_q <= editX_q;
            dispY_q <= editY_q;
            dispR_q <= editR_q;
         end
         d2_q   <= d2_d;
         r2_q   <= r2_d;
`ifdef CIRCLE_OUTLINE_EN
         rIn2_q <= rIn2_d;
`endif
         bg_q   <= bus.bg_color;
         vga_q  <= vga_d;
         hit_q  <= hit_d;
      end
   end

   assign bus.vga_data = vga_q;
   assign bus.hit      = hit_q;
   assign bus.sel_idx  = selIdx_q;
   assign bus.sel_x    = editX_q[selIdx_q];
   assign bus.sel_y    = editY_q[selIdx_q][8:0];
   assign bus.sel_r    = editR_q[selIdx_q];
endmodule

// File: tb/tb_multi_circle_renderer.sv
// Bench for multi_circle_renderer: constant pixel table, hand-written edit sequences and
// a randomized stream checked against an arithmetic model of the circle set.
module tb_multi_circle_renderer;
   localparam int N = 4, H = 640, V = 480, SXY = 20, SR = 5, RMIN = 5, RMAX = 200, RINIT = 15, W = 3;
   localparam int C0 = 'h00F, C1 = 'h0F0, C2 = 'hF00, C3 = 'h888, BG = 'h123;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   multi_circle_renderer_if #(.N_CIRCLES(N)) bus();

   multi_circle_renderer #(
      .N_CIRCLES(N), .H_RES(H), .V_RES(V), .STEP_XY(SXY), .STEP_R(SR),
      .R_MIN(RMIN), .R_MAX(RMAX), .R_INIT(RINIT), .OUTLINE_W(W)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
   );

   typedef struct { int vga; int hit; } pix_t;
   typedef struct { int col; int row; int vga; int hit; } vec_t;

   int   checkCount = 0;
   int   errorCount = 0;
   int   colors [N] = '{C0, C1, C2, C3};
   int   mEditX [N], mEditY [N], mEditR [N];
   int   mDispX [N], mDispY [N], mDispR [N];
   int   mSel;
   bit   mWas;
   pix_t pending [$];
   vec_t vecs [11];
   int   codes [13] = '{0, 1, 2, 3, 'hc, 'he, 'h9, 'h11, 'h10, 'h12, 'h5, 'h1f, 'h4};

   function automatic int clampInt(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic resetModel();
      for (int i = 0; i < N; i++) begin
         mEditX[i] = (2 * i + 1) * H / (2 * N);
         mEditY[i] = V / 2;
         mEditR[i] = RINIT;
         mDispX[i] = mEditX[i];
         mDispY[i] = mEditY[i];
         mDispR[i] = mEditR[i];
      end
      mSel = 0;
      mWas = 1'b0;
      pending.delete();
   endtask

   function automatic pix_t modelPixel(int c, int r);
      pix_t p;
      p.vga = BG;
      p.hit = 0;
      for (int i = N - 1; i >= 0; i--) begin
         int d2;
         bit h;
         d2 = (c - mDispX[i]) * (c - mDispX[i]) + (r - mDispY[i]) * (r - mDispY[i]);
         h  = d2 < mDispR[i] * mDispR[i];
`ifdef CIRCLE_OUTLINE_EN
         if (mDispR[i] > W) h = h && (d2 >= (mDispR[i] - W) * (mDispR[i] - W));
`endif
         if (h) begin
            p.hit = p.hit | (1 << i);
            p.vga = colors[i];
         end
      end
      return p;
   endfunction

   // Model of one clock edge with the inputs currently on the bus.
   task automatic modelEdge();
      if (bus.frame_start) begin
         mDispX = mEditX;
         mDispY = mEditY;
         mDispR = mEditR;
      end
      if (bus.key_ready && !mWas) begin
         case (int'(bus.key_code))
            0, 1, 2, 3: if (int'(bus.key_code) < N) mSel = int'(bus.key_code);
            'hc:  mEditX[mSel] = clampInt(mEditX[mSel] - SXY, 0, H - 1);
            'he:  mEditX[mSel] = clampInt(mEditX[mSel] + SXY, 0, H - 1);
            'h9:  mEditY[mSel] = clampInt(mEditY[mSel] - SXY, 0, V - 1);
            'h11: mEditY[mSel] = clampInt(mEditY[mSel] + SXY, 0, V - 1);
            'h10: mEditR[mSel] = clampInt(mEditR[mSel] - SR, RMIN, RMAX);
            'h12: mEditR[mSel] = clampInt(mEditR[mSel] + SR, RMIN, RMAX);
            default: ;
         endcase
      end
      mWas = bus.key_ready;
   endtask

   task automatic checkOutput(string name, int actual, int expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // One clock: queue the expected pixel, advance the model, compare outputs after the edge.
   task automatic applyStimulus();
      pix_t p;
      p = modelPixel(int'(bus.col_addr), int'(bus.row_addr));
      pending.push_back(p);
      @(posedge clk);
      modelEdge();
      #1;
      if (pending.size() >= 2) begin
         p = pending.pop_front();
         checkOutput("stream.vga", int'(bus.vga_data), p.vga);
         checkOutput("stream.hit", int'(bus.hit), p.hit);
      end
      checkOutput("stream.sel_idx", int'(bus.sel_idx), mSel);
      checkOutput("stream.sel_x", int'(bus.sel_x), mEditX[mSel]);
      checkOutput("stream.sel_y", int'(bus.sel_y), mEditY[mSel]);
      checkOutput("stream.sel_r", int'(bus.sel_r), mEditR[mSel]);
   endtask

   task automatic checkPixel(string name, int c, int r, int expVga, int expHit);
      bus.col_addr = 10'(c);
      bus.row_addr = 9'(r);
      applyStimulus();
      applyStimulus();
      checkOutput({name, ".vga"}, int'(bus.vga_data), expVga);
      checkOutput({name, ".hit"}, int'(bus.hit), expHit);
   endtask

   task automatic press(int code);
      bus.key_code  = 5'(code);
      bus.key_ready = 1'b1;
      applyStimulus();
      bus.key_ready = 1'b0;
      applyStimulus();
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      applyStimulus();
      bus.frame_start = 1'b0;
   endtask

   task automatic applyReset();
      rstn            = 1'b0;
      bus.key_ready   = 1'b0;
      bus.frame_start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset.vga", int'(bus.vga_data), 0);
      checkOutput("reset.hit", int'(bus.hit), 0);
      @(posedge clk);
      #1;
      checkOutput("reset.sel_idx", int'(bus.sel_idx), 0);
      checkOutput("reset.sel_x", int'(bus.sel_x), 80);
      checkOutput("reset.sel_y", int'(bus.sel_y), 240);
      checkOutput("reset.sel_r", int'(bus.sel_r), 15);
      resetModel();
      rstn = 1'b1;
   endtask

   initial begin
      int k;
      vecs[0]  = '{94, 240, C0, 1};
      vecs[1]  = '{95, 240, BG, 0};
      vecs[2]  = '{80, 253, C0, 1};
      vecs[3]  = '{80, 255, BG, 0};
      vecs[4]  = '{227, 240, C1, 2};
      vecs[5]  = '{413, 240, C2, 4};
      vecs[6]  = '{560, 226, C3, 8};
      vecs[7]  = '{0, 0, BG, 0};
      vecs[8]  = '{639, 479, BG, 0};
      vecs[9]  = '{65, 240, BG, 0};
      vecs[10] = '{66, 240, C0, 1};

      bus.key_code    = '0;
      bus.key_ready   = 1'b0;
      bus.frame_start = 1'b0;
      bus.col_addr    = '0;
      bus.row_addr    = '0;
      bus.color_in    = {12'(C3), 12'(C2), 12'(C1), 12'(C0)};
      bus.bg_color    = 12'(BG);
      applyReset();

      frame();
      for (int i = 0; i < 11; i++)
         checkPixel($sformatf("table%0d", i), vecs[i].col, vecs[i].row, vecs[i].vga, vecs[i].hit);
`ifdef CIRCLE_OUTLINE_EN
      checkPixel("ring.d13", 93, 240, C0, 1);
      checkPixel("ring.d11", 91, 240, BG, 0);
`else
      checkPixel("fill.center0", 80, 240, C0, 1);
`endif

      // Move circle 1 right by three steps; old position stays on screen until frame_start.
      press(1);
      repeat (3) press('he);
      checkOutput("move.sel_x", int'(bus.sel_x), 300);
      checkPixel("move.before", 227, 240, C1, 2);
      frame();
      checkPixel("move.after", 287, 240, C1, 2);
      checkPixel("move.oldgone", 240, 240, BG, 0);
`ifndef CIRCLE_OUTLINE_EN
      checkPixel("move.center", 300, 240, C1, 2);
`endif

      // Held key gives a single step; then saturate both radius limits.
      bus.key_code  = 5'h12;
      bus.key_ready = 1'b1;
      repeat (100) applyStimulus();
      bus.key_ready = 1'b0;
      applyStimulus();
      checkOutput("hold.sel_r", int'(bus.sel_r), 20);
      repeat (50) press('h12);
      checkOutput("rmax.sel_r", int'(bus.sel_r), 200);
      repeat (50) press('h10);
      checkOutput("rmin.sel_r", int'(bus.sel_r), 5);

      // Circle 0 pushed past the left edge clamps at x=0.
      press(0);
      repeat (10) press('hc);
      checkOutput("xclamp.sel_x", int'(bus.sel_x), 0);
      frame();
      checkPixel("xclamp.d13", 13, 240, C0, 1);
      checkPixel("xclamp.d15", 15, 240, BG, 0);
`ifndef CIRCLE_OUTLINE_EN
      checkPixel("xclamp.d5", 5, 240, C0, 1);
`endif

      // Overlap: circle 1 onto circle 0, lower index wins the colour.
      press(1);
      repeat (15) press('hc);
      checkOutput("overlap.sel_x", int'(bus.sel_x), 0);
      frame();
`ifndef CIRCLE_OUTLINE_EN
      checkPixel("overlap.shared", 2, 240, C0, 3);
`endif

      // Key event and frame_start on the same edge: display keeps the pre-edit value.
      press(2);
      bus.key_code    = 5'he;
      bus.key_ready   = 1'b1;
      bus.frame_start = 1'b1;
      applyStimulus();
      bus.key_ready   = 1'b0;
      bus.frame_start = 1'b0;
      applyStimulus();
      checkOutput("same.sel_x", int'(bus.sel_x), 420);
      checkPixel("same.old", 387, 240, C2, 4);
      frame();
      checkPixel("same.new", 387, 240, BG, 0);

      // Randomized stream, biased towards pixels near displayed circles.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            k = int'($urandom_range(0, N - 1));
            bus.col_addr = 10'(clampInt(mDispX[k] + int'($urandom_range(0, 2 * mDispR[k] + 2)) - mDispR[k] - 1, 0, H - 1));
            bus.row_addr = 9'(clampInt(mDispY[k] + int'($urandom_range(0, 2 * mDispR[k] + 2)) - mDispR[k] - 1, 0, V - 1));
         end else begin
            bus.col_addr = 10'($urandom_range(0, H - 1));
            bus.row_addr = 9'($urandom_range(0, V - 1));
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.key_ready = 1'($urandom_range(0, 1));
            bus.key_code  = 5'(codes[$urandom_range(0, 12)]);
         end
         bus.frame_start = ($urandom_range(0, 29) == 0);
         applyStimulus();
      end
      bus.key_ready   = 1'b0;
      bus.frame_start = 1'b0;

      // Reset in the middle of a line flushes the pipeline on the next edge, then resumes.
      bus.col_addr = 10'(mDispX[2]);
      bus.row_addr = 9'(mDispY[2]);
      applyStimulus();
      applyStimulus();
      applyReset();
      checkPixel("postreset", 94, 240, C0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule

// File: doc/multi_circle_renderer.md
# multi_circle_renderer

Parametrised VGA overlay renderer drawing up to N_CIRCLES independently positioned, sized and coloured circles over a background colour. It sits between the keypad decoder (key_code/key_ready) and the VGA timing controller: it takes the controller's pixel address and returns the 12-bit BGR pixel two cycles later. Edits are double-buffered and applied at frame boundaries, so the display never tears. Per-circle state is exported for seven-segment display.

## Interface
- N_CIRCLES, 4: number of circles, 1..4.
- H_RES, 640: horizontal resolution; x range 0..H_RES-1.
- V_RES, 480: vertical resolution; y range 0..V_RES-1.
- STEP_XY, 20: position step per key press.
- STEP_R, 5: radius step per key press.
- R_MIN, 5 / R_MAX, 200: radius saturation limits.
- R_INIT, 15: reset radius.
- OUTLINE_W, 3: ring thickness; used only with CIRCLE_OUTLINE_EN.

- clk  in  1  pixel-domain clock.
- rstn  in  1  synchronous, active-low reset.
- key_code  in  5  keypad code, valid while key_ready=1.
- key_ready  in  1  level; high while a key is held.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- col_addr  in  10  current pixel column.
- row_addr  in  9  current pixel row.
- color_in  in  12*N_CIRCLES  colour of circle i in bits [12i+11:12i], BGR.
- bg_color  in  12  background colour.
- vga_data  out  12  registered pixel colour; reset 12'h000.
- hit  out  N_CIRCLES  registered per-circle coverage of the pixel in vga_data; reset 0.
- sel_idx  out  2  currently selected circle; reset 0.
- sel_x  out  10 / sel_y  out  9 / sel_r  out  10: edit-copy state of the selected circle; reset to circle 0's reset values.

## Operation
- Reset values for circle i: x = (2i+1)*H_RES/(2*N_CIRCLES), y = V_RES/2, r = R_INIT. Edit and display copies are both loaded. wasReady = 0.
- Key event: rising edge of key_ready (key_ready=1, registered wasReady=0). Holding a key produces no repeats.
- Key map, applied to the edit copy of circle sel_idx:
  - 5'h0..5'h3: set sel_idx. Codes ≥ N_CIRCLES are ignored.
  - 5'hc: x -= STEP_XY.
  - 5'he: x += STEP_XY.
  - 5'h9: y -= STEP_XY.
  - 5'h11: y += STEP_XY.
  - 5'h10: r -= STEP_R.
  - 5'h12: r += STEP_R.
  - All other codes: no effect.
- Saturation, not wrap-around:
  - x clamps to [0, H_RES-1].
  - y clamps to [0, V_RES-1].
  - r clamps to [R_MIN, R_MAX].
  - Arithmetic is done at 11 bits signed before the clamp.
- Display copy: on frame_start=1, every display register loads its edit copy. If a key event and frame_start occur in the same cycle, the display copy takes the pre-edit value and the edit appears on the following frame.
- Pixel pipeline, using display copies:
  - Stage 1 registers, per circle: d2 = dx² + dy², where dx = col-x and dy = row-y are 11-bit signed and d2 is 21-bit unsigned. Also registers r² (20-bit) and bg_color.
  - Stage 2: hit[i] = (d2 < r²), strictly less.
  - vga_data = color of the lowest-index hit circle, else the stage-1 bg_color.
- Reset mid-frame: the pipeline flushes to 12'h000 / hit=0 on the next edge. Output resumes with a latency of 2.

## Timing
- Pixel latency: exactly 2 clk from col_addr/row_addr to vga_data/hit. Throughput is 1 pixel per clk.
- Key edge at cycle n:
  - Edit copy and sel_* outputs update at edge n+1.
  - Display updates at the first frame_start after that.
- sel_* outputs are registered; no combinational input-to-output path.

## Configuration
- CIRCLE_OUTLINE_EN defined: hit[i] = (d2 < r²) && (d2 ≥ (r-OUTLINE_W)²). When r ≤ OUTLINE_W the circle is drawn filled. Adds one (r-OUTLINE_W)² register per circle in stage 1; latency is unchanged.
- Undefined: filled circles only; OUTLINE_W is ignored.

## Test plan
- Reset, N=4, then frame_start. Pixel (80,240) → after 2 clk, vga_data = color_in[11:0] and hit = 4'b0001. Pixel (0,0) → bg_color, hit = 0.
- Select circle 1 (code 5'h1), press 5'he ×3, then frame_start. sel_x = 300. Pixel (300,240) hits circle 1 and (240,240) does not. Before frame_start, circle 1 is still drawn at x=240.
- Hold key_ready=1 with code 5'h12 for 100 clk → r increments once (15→20). Press 5'h12 ×50 → r = 200. Press 5'h10 ×50 → r = 5.
- Circle 0 pressed 5'hc ×10 → x = 0 (no wrap). Pixel (5,240) hits with r=15. Pixel (15,240) misses (d2 = 225, not < 225).
- Overlap: move circle 1 onto circle 0 → shared pixel shows color 0 and hit = 4'b0011. Key event and frame_start in the same cycle → change visible one frame later.
- CIRCLE_OUTLINE_EN, r=15, W=3: pixel at distance 13 → hit. Distance 11 → bg_color. rstn low mid-line → vga_data = 12'h000 on the next edge.
